// File: rtl/nn_dot_engine.sv
// Signed int8 dot-product engine: a CSR slave plus an Avalon-MM read master that fetches weight/input word pairs.
// Optional macro NN_DOT_RELU_EN adds CTRL bit2 RELU, which clamps a negative RESULT to 0.
module nn_dot_engine #(
   parameter int ACC_W = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic [31:0]      avm_address,
   output logic             avm_read,
   input  logic             avm_waitrequest,
   input  logic [31:0]      avm_readdata,
   input  logic             avm_readdatavalid,
   output logic             irq
);

   typedef enum logic [2:0] {IDLE, RD_W, WAIT_W, RD_X, WAIT_X, MAC, FIN} state_t;

   localparam logic signed [33:0] ACC_MAX = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;
   localparam logic signed [33:0] ACC_MIN = -(34'sd1 <<< (ACC_W - 1));

   state_t                   state;
   logic                     irq_en;
   logic                     done;
   logic [31:0]              w_addr;
   logic [31:0]              x_addr;
   logic [LEN_W-1:0]         len;
   logic [LEN_W-1:0]         count;
   logic [31:0]              wptr;
   logic [31:0]              xptr;
   logic [31:0]              w_word;
   logic [31:0]              x_word;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  result;
   logic signed [7:0]        w_byte;
   logic signed [7:0]        x_byte;
   logic signed [15:0]       prod;
   logic signed [17:0]       dot_sum;
   logic signed [33:0]       acc_wide;
   logic [31:0]              ctrl_rd;
   logic                     busy;
   logic                     start_req;

`ifdef NN_DOT_RELU_EN
   logic                     relu;
   assign ctrl_rd = {29'b0, relu, irq_en, 1'b0};
`else
   assign ctrl_rd = {30'b0, irq_en, 1'b0};
`endif

   assign busy      = (state != IDLE);
   assign start_req = avs_write && (avs_address == 3'd0) && avs_writedata[0] && !busy;

   // Four signed byte products summed at 18 bits, then a saturating add into the accumulator.
   always_comb begin
      dot_sum = '0;
      w_byte  = '0;
      x_byte  = '0;
      prod    = '0;
      for (int i = 0; i < 4; i++) begin
         w_byte  = w_word[8*i +: 8];
         x_byte  = x_word[8*i +: 8];
         prod    = 16'(w_byte) * 16'(x_byte);
         dot_sum = dot_sum + 18'(prod);
      end
      acc_wide = 34'(acc) + 34'(dot_sum);
      if (acc_wide > ACC_MAX)
         acc_next = ACC_MAX[ACC_W-1:0];
      else if (acc_wide < ACC_MIN)
         acc_next = ACC_MIN[ACC_W-1:0];
      else
         acc_next = acc_wide[ACC_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         avs_readdata <= '0;
         avm_address  <= '0;
         avm_read     <= 1'b0;
         irq          <= 1'b0;
         irq_en       <= 1'b0;
         done         <= 1'b0;
         w_addr       <= '0;
         x_addr       <= '0;
         len          <= '0;
         count        <= '0;
         wptr         <= '0;
         xptr         <= '0;
         w_word       <= '0;
         x_word       <= '0;
         acc          <= '0;
         result       <= '0;
`ifdef NN_DOT_RELU_EN
         relu         <= 1'b0;
`endif
      end else begin
         irq <= done & irq_en;

         if (avs_read) begin
            case (avs_address)
               3'd0:    avs_readdata <= ctrl_rd;
               3'd1:    avs_readdata <= {30'b0, done, busy};
               3'd2:    avs_readdata <= w_addr;
               3'd3:    avs_readdata <= x_addr;
               3'd4:    avs_readdata <= 32'(len);
               3'd5:    avs_readdata <= 32'(result);
               default: avs_readdata <= '0;
            endcase
         end

         // The DONE clear comes before the FSM so that a START in the same cycle overrides it.
         if (avs_write) begin
            case (avs_address)
               3'd0: begin
                  irq_en <= avs_writedata[1];
`ifdef NN_DOT_RELU_EN
                  relu   <= avs_writedata[2];
`endif
               end
               3'd1: if (avs_writedata[1]) done <= 1'b0;
               3'd2: if (!busy) w_addr <= {avs_writedata[31:2], 2'b00};
               3'd3: if (!busy) x_addr <= {avs_writedata[31:2], 2'b00};
               3'd4: if (!busy) len <= avs_writedata[LEN_W-1:0];
               default: ;
            endcase
         end

         case (state)
            IDLE: begin
               if (start_req) begin
                  if (len != '0) begin
                     acc         <= '0;
                     wptr        <= w_addr;
                     xptr        <= x_addr;
                     count       <= len;
                     done        <= 1'b0;
                     avm_read    <= 1'b1;
                     avm_address <= w_addr;
                     state       <= RD_W;
                  end else begin
                     result <= '0;
                     done   <= 1'b1;
                  end
               end
            end
            RD_W: begin
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  state    <= WAIT_W;
               end
            end
            WAIT_W: begin
               if (avm_readdatavalid) begin
                  w_word      <= avm_readdata;
                  avm_read    <= 1'b1;
                  avm_address <= xptr;
                  state       <= RD_X;
               end
            end
            RD_X: begin
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  state    <= WAIT_X;
               end
            end
            WAIT_X: begin
               if (avm_readdatavalid) begin
                  x_word <= avm_readdata;
                  state  <= MAC;
               end
            end
            MAC: begin
               acc   <= acc_next;
               wptr  <= wptr + 32'd4;
               xptr  <= xptr + 32'd4;
               count <= count - 1'b1;
               if (count == LEN_W'(1)) begin
                  state <= FIN;
               end else begin
                  avm_read    <= 1'b1;
                  avm_address <= wptr + 32'd4;
                  state       <= RD_W;
               end
            end
            FIN: begin
`ifdef NN_DOT_RELU_EN
               result <= (relu && acc[ACC_W-1]) ? '0 : acc;
`else
               result <= acc;
`endif
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_dot_engine.sv
// Directed self-checking bench for nn_dot_engine with an SDRAM-like read responder (stall and latency adjustable).
module tb_nn_dot_engine;

   localparam int ACC_W = 20;
   localparam int LEN_W = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  avs_address = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0;
   logic        irq;

   int assert_count = 0;
   int fail_count = 0;

   logic [31:0] mem [0:127];
   logic [31:0] read_log [$];
   int          stall_en = 0;
   int          lat = 1;
   int          stall_cnt = 0;
   int          stall_cycles = 0;
   int          stall_err = 0;
   int          pend_cnt = 0;
   logic [31:0] pend_data = '0;
   logic [31:0] hold_addr = '0;
   logic [31:0] rd;

   nn_dot_engine #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk),
      .reset(reset),
      .avs_address(avs_address),
      .avs_read(avs_read),
      .avs_write(avs_write),
      .avs_writedata(avs_writedata),
      .avs_readdata(avs_readdata),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .irq(irq)
   );

   always #5 clk = ~clk;

   assign avm_waitrequest = (stall_en != 0) && avm_read && (stall_cnt < 5);

   // Memory responder: one accepted read returns data lat cycles later; it ignores the DUT reset on purpose.
   always @(posedge clk) begin
      avm_readdatavalid <= 1'b0;
      if (pend_cnt != 0) begin
         pend_cnt <= pend_cnt - 1;
         if (pend_cnt == 1) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata      <= pend_data;
         end
      end
      if (reset) begin
         stall_cnt <= 0;
      end else if (avm_read && !avm_waitrequest) begin
         read_log.push_back(avm_address);
         pend_cnt  <= lat;
         pend_data <= mem[avm_address[8:2]];
         stall_cnt <= 0;
      end else if (avm_read) begin
         stall_cnt <= stall_cnt + 1;
         stall_cycles = stall_cycles + 1;
         if (stall_cnt != 0 && avm_address != hold_addr) stall_err = stall_err + 1;
      end else if (stall_cnt != 0) begin
         stall_err = stall_err + 1;
         stall_cnt <= 0;
      end
      hold_addr <= avm_address;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d           = avs_readdata;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      bit          idle;
      idle = 1'b0;
      for (int i = 0; i < 400 && !idle; i++) begin
         csr_read(3'd1, s);
         if (!s[0]) idle = 1'b1;
      end
      if (!idle) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic applyStimulus(input logic [31:0] w, input logic [31:0] x,
                                input logic [31:0] n, input logic [31:0] ctrl, input string tag);
      csr_write(3'd2, w);
      csr_write(3'd3, x);
      csr_write(3'd4, n);
      csr_write(3'd0, ctrl | 32'd1);
      wait_idle(tag);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_readdata", avs_readdata, 32'd0);
      checkOutput("rst_avm_read", {31'b0, avm_read}, 32'd0);
      reset = 1'b0;
      checkOutput("rst_avm_addr", avm_address, 32'd0);
      checkOutput("rst_irq", {31'b0, irq}, 32'd0);
      for (int a = 0; a < 8; a++) begin
         csr_read(3'(a), rd);
         checkOutput($sformatf("rst_csr%0d", a), rd, 32'd0);
      end

      // Basic run
      mem[0] = 32'h01020304; mem[64] = 32'h01010101;
      read_log.delete();
      applyStimulus(32'h0000_0000, 32'h0000_0100, 32'd1, 32'd0, "basic");
      csr_read(3'd5, rd); checkOutput("basic_result", rd, 32'd10);
      csr_read(3'd1, rd); checkOutput("basic_status", rd, 32'd2);
      checkOutput("basic_nreads", 32'(read_log.size()), 32'd2);
      if (read_log.size() == 2) begin
         checkOutput("basic_addr0", read_log[0], 32'h0000_0000);
         checkOutput("basic_addr1", read_log[1], 32'h0000_0100);
      end
      csr_write(3'd2, 32'h1234_567B);
      csr_read(3'd2, rd); checkOutput("waddr_low_bits", rd, 32'h1234_5678);

      // Signed mixed
      mem[0] = 32'h80FF7F02; mem[1] = 32'h00000001;
      mem[64] = 32'h7F01FF03; mem[65] = 32'h000000FF;
      applyStimulus(32'h0, 32'h100, 32'd2, 32'd0, "signed");
      csr_read(3'd5, rd); checkOutput("signed_result", rd, 32'hFFFFC005);
`ifdef NN_DOT_RELU_EN
      applyStimulus(32'h0, 32'h100, 32'd2, 32'd4, "relu");
      csr_read(3'd5, rd); checkOutput("relu_result", rd, 32'd0);
      csr_read(3'd0, rd); checkOutput("relu_ctrl", rd, 32'd4);
`else
      csr_write(3'd0, 32'd4);
      csr_read(3'd0, rd); checkOutput("ctrl_bit2_ro", rd, 32'd0);
`endif
      csr_write(3'd0, 32'd0);

      // Waitrequest stall
      mem[0] = 32'h01020304; mem[64] = 32'h01010101;
      stall_en = 1; stall_cycles = 0; stall_err = 0;
      read_log.delete();
      applyStimulus(32'h0, 32'h100, 32'd1, 32'd0, "stall");
      csr_read(3'd5, rd); checkOutput("stall_result", rd, 32'd10);
      checkOutput("stall_cycles", 32'(stall_cycles), 32'd10);
      checkOutput("stall_stable", 32'(stall_err), 32'd0);
      checkOutput("stall_nreads", 32'(read_log.size()), 32'd2);
      stall_en = 0;

      // LEN=0 start with interrupt
      read_log.delete();
      csr_write(3'd4, 32'd0);
      csr_write(3'd0, 32'd3);
      csr_read(3'd1, rd); checkOutput("len0_status", rd, 32'd2);
      csr_read(3'd5, rd); checkOutput("len0_result", rd, 32'd0);
      checkOutput("len0_irq", {31'b0, irq}, 32'd1);
      checkOutput("len0_noreads", 32'(read_log.size()), 32'd0);
      csr_write(3'd1, 32'd2);
      @(negedge clk);
      checkOutput("w1c_irq", {31'b0, irq}, 32'd0);
      csr_read(3'd1, rd); checkOutput("w1c_status", rd, 32'd0);
      csr_write(3'd0, 32'd0);

      // Saturation at ACC_W=20, then one negative pair pulls it off the rail
      for (int i = 0; i < 20; i++) begin
         mem[i] = 32'h7F7F7F7F; mem[64+i] = 32'h7F7F7F7F;
      end
      applyStimulus(32'h0, 32'h100, 32'd20, 32'd0, "sat");
      csr_read(3'd5, rd); checkOutput("sat_result", rd, 32'h0007FFFF);
      mem[20] = 32'h81818181; mem[84] = 32'h7F7F7F7F;
      applyStimulus(32'h0, 32'h100, 32'd21, 32'd0, "desat");
      csr_read(3'd5, rd); checkOutput("desat_result", rd, 32'd459771);

      // Busy rules
      mem[0] = 32'h01020304; mem[64] = 32'h01010101;
      stall_en = 1;
      csr_write(3'd4, 32'd1);
      csr_write(3'd0, 32'd1);
      csr_write(3'd4, 32'd9);
      csr_read(3'd4, rd); checkOutput("busy_len", rd, 32'd1);
      csr_read(3'd1, rd); checkOutput("busy_status", rd, 32'd1);
      csr_write(3'd0, 32'd2);
      csr_read(3'd0, rd); checkOutput("busy_irq_en", rd, 32'd2);
      wait_idle("busy");
      @(negedge clk);
      checkOutput("busy_irq", {31'b0, irq}, 32'd1);
      csr_read(3'd5, rd); checkOutput("busy_result", rd, 32'd10);

      // Reset while the X read is stalled
      csr_write(3'd0, 32'd1);
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (avm_read && avm_address == 32'h100) found = 1'b1;
         end
         if (!found) checkOutput("rdx_timeout", 32'd1, 32'd0);
      end
      reset = 1'b1;
      #1;
      checkOutput("abort_avm_read", {31'b0, avm_read}, 32'd0);
      checkOutput("abort_avm_addr", avm_address, 32'd0);
      checkOutput("abort_irq", {31'b0, irq}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stall_en = 0;
      csr_read(3'd1, rd); checkOutput("abort_status", rd, 32'd0);
      csr_read(3'd5, rd); checkOutput("abort_result", rd, 32'd0);

      // Reset in WAIT_X with a late readdatavalid
      lat = 4;
      read_log.delete();
      csr_write(3'd3, 32'h100);
      csr_write(3'd4, 32'd1);
      csr_write(3'd0, 32'd1);
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (read_log.size() == 2) found = 1'b1;
         end
         if (!found) checkOutput("waitx_timeout", 32'd1, 32'd0);
      end
      reset = 1'b1;
      #1;
      checkOutput("waitx_avm_read", {31'b0, avm_read}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      lat = 1;
      read_log.delete();
      applyStimulus(32'h0, 32'h100, 32'd1, 32'd0, "post_reset");
      csr_read(3'd5, rd); checkOutput("post_reset_result", rd, 32'd10);
      checkOutput("post_reset_nreads", 32'(read_log.size()), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
